// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch/execute sequencer for the MIPS core: runs a request/ack
// instruction fetch, a one-cycle execute window with branch/jump redirect, and stall/halt/resume.
module pc_fetch_sequencer #(
  parameter int                PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  input  logic            branch,
  input  logic            zero,
  input  logic [31:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_addr,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;

  // Only the low PC_W bits of the immediate and jump field address the PC.
  logic unused_bits;
  assign unused_bits = ^{branch_offset[31:PC_W], jump_addr[25:PC_W]};

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_pc = pc_q + PC_W'(1);
    if (branch && zero) begin
      next_pc = pc_q + branch_offset[PC_W-1:0] + PC_W'(1);
    end else if (jump) begin
      next_pc = jump_addr[PC_W-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // imem_req and instr_valid are set alongside the state they belong to, so they are pure flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            state_q     <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q        <= next_pc;
            instr_valid <= 1'b0;
            if (halt) begin
              state_q <= HALT;
            end else begin
              state_q  <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state_q  <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a cycle-level reference model is
// compared on every falling edge, plus literal spot checks from the main thread.
module tb_pc_fetch_sequencer;

  localparam int PC_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_addr;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model: state as 0 idle, 1 fetch, 2 exec, 3 halt; pc as a plain integer.
  int m_state;
  int m_pc;

  pc_fetch_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .stall         (stall),
    .halt          (halt),
    .resume        (resume),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_target(input int pc_v, input bit br, input bit z,
                                      input logic [31:0] off, input bit j, input logic [25:0] ja);
    if (br && z) return (pc_v + int'(off) + 1) & 255;
    if (j)       return int'(ja) & 255;
    return (pc_v + 1) & 255;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_state <= 0;
      m_pc    <= 0;
    end else begin
      case (m_state)
        0: m_state <= 1;
        1: if (imem_ack) m_state <= 2;
        2: if (!stall) begin
             m_pc    <= model_target(m_pc, branch, zero, branch_offset, jump, jump_addr);
             m_state <= halt ? 3 : 1;
           end
        default: if (resume) m_state <= 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_state", 32'(state), 32'(m_state));
      check("model_pc", 32'(pc), 32'(m_pc));
      check("model_addr", 32'(imem_addr), 32'(m_pc));
      check("model_req", 32'(imem_req), 32'(m_state == 1));
      check("model_valid", 32'(instr_valid), 32'(m_state == 2));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From EXEC with imem_ack held high: jump to target and land in its EXEC cycle.
  task automatic redirect_to(input logic [7:0] target);
    branch = 1'b0; zero = 1'b0; jump = 1'b1; jump_addr = 26'(target);
    tick();
    jump = 1'b0;
    tick();
    check("redirect_pc", 32'(pc), 32'(target));
  endtask

  // From EXEC: apply redirect inputs, check the new fetch address, return to EXEC.
  task automatic exec_with(input string name, input bit br, input bit z, input logic [31:0] off,
                           input bit j, input logic [25:0] ja, input logic [7:0] exp_pc);
    branch = br; zero = z; branch_offset = off; jump = j; jump_addr = ja;
    tick();
    check({name, "_addr"}, 32'(imem_addr), 32'(exp_pc));
    check({name, "_state"}, 32'(state), 32'h1);
    branch = 1'b0; zero = 1'b0; branch_offset = '0; jump = 1'b0; jump_addr = '0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_addr = '0; stall = 1'b0; halt = 1'b0; resume = 1'b0;

    tick(2);
    check("rst_state", 32'(state), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check_en = 1'b1;

    // Sequential run with immediate acks.
    reset_n = 1'b1; imem_ack = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("seq_fetch_state", 32'(state), 32'h1);
      check("seq_fetch_addr", 32'(imem_addr), 32'(i));
      check("seq_fetch_valid", 32'(instr_valid), 32'h0);
      tick();
      check("seq_exec_state", 32'(state), 32'h2);
      check("seq_exec_valid", 32'(instr_valid), 32'h1);
      tick();
    end

    // Fetch wait: three ack-less cycles at pc=05.
    tick();
    imem_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wait_req", 32'(imem_req), 32'h1);
      check("wait_addr", 32'(imem_addr), 32'h05);
      check("wait_valid", 32'(instr_valid), 32'h0);
      if (i == 3) imem_ack = 1'b1;
      tick();
    end
    check("wait_exec_valid", 32'(instr_valid), 32'h1);

    // Redirects.
    redirect_to(8'h10);
    exec_with("br_fwd", 1'b1, 1'b1, 32'h0000_0004, 1'b0, 26'h0, 8'h15);
    redirect_to(8'h10);
    exec_with("br_back", 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, 8'h01);
    redirect_to(8'h10);
    exec_with("br_nottaken", 1'b1, 1'b0, 32'h0000_0004, 1'b0, 26'h0, 8'h11);
    redirect_to(8'h10);
    exec_with("jump", 1'b0, 1'b0, 32'h0, 1'b1, 26'h00000A7, 8'hA7);
    exec_with("jump_hibits", 1'b0, 1'b0, 32'h0, 1'b1, 26'h2AAAAA5, 8'hA5);
    redirect_to(8'h10);
    exec_with("br_over_jump", 1'b1, 1'b1, 32'h0000_0002, 1'b1, 26'h00000A7, 8'h13);
    redirect_to(8'h02);
    exec_with("br_wrap", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 8'hFF);
    exec_with("seq_wrap", 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 8'h00);

    // Stall two cycles with jump pending, then retire with halt.
    stall = 1'b1; jump = 1'b1; jump_addr = 26'h000003C;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_pc", 32'(pc), 32'h00);
      if (i == 2) begin stall = 1'b0; halt = 1'b1; end
      tick();
    end
    check("halt_state", 32'(state), 32'h3);
    check("halt_pc", 32'(pc), 32'h3C);
    check("halt_req", 32'(imem_req), 32'h0);
    jump = 1'b0;
    tick(2);
    check("halt_hold", 32'(state), 32'h3);
    halt = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_state", 32'(state), 32'h1);
    check("resume_addr", 32'(imem_addr), 32'h3C);

    // Reset during EXEC with a taken branch pending.
    tick();
    check("pre_rst_exec", 32'(state), 32'h2);
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h4; reset_n = 1'b0;
    tick();
    check("midrst_state", 32'(state), 32'h0);
    check("midrst_pc", 32'(pc), 32'h00);
    branch = 1'b0; zero = 1'b0; branch_offset = '0;
    tick();
    check("rst_hold_state", 32'(state), 32'h0);
    reset_n = 1'b1;
    tick();
    check("stray_ack_state", 32'(state), 32'h1);
    imem_ack = 1'b0;
    tick();
    check("post_rst_fetch", 32'(state), 32'h1);
    check("post_rst_addr", 32'(imem_addr), 32'h00);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
